// File: rtl/alu_result_uart_tx_if.sv
// Result-byte handshake between the ALU result register and the UART serializer.
// The source holds res_data stable while res_valid is high and res_ready is low.
interface alu_result_uart_tx_if;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/alu_result_uart_tx.sv
// 8N1 LSB-first serializer for ALU result bytes with a one-byte holding register.
// The holding register lets the next byte queue up while a frame is on the wire.
module alu_result_uart_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_result_uart_tx_if.slave  bus,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   baud_q, baud_d;

  logic            accept;
  logic            baud_end;
  logic            load;

  assign bus.res_ready = !hold_full_q;
  assign accept        = bus.res_valid && !hold_full_q;
  assign baud_end      = (baud_q == BAUD_LAST);
  assign busy          = (state_q != IDLE) || hold_full_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    load    = 1'b0;
    tx      = 1'b1;
    tx_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (baud_end) begin
          tx_done = 1'b1;
          baud_d  = '0;
          // a queued byte starts its frame with no idle gap
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      shift_d = hold_q;
    end
  end

  // load only happens when full and accept only when empty, so they never collide
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    unique case (1'b1)
      accept: begin
        hold_d      = bus.res_data;
        hold_full_d = 1'b1;
      end
      load: begin
        hold_full_d = 1'b0;
      end
      default: begin
        hold_full_d = hold_full_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_q       <= '0;
      baud_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: two instances (CLK_DIV 4 and 2) checked
// every cycle against a frame-schedule model, plus literal waveform points.
module tb_alu_result_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_uart_tx_if bus0 ();
  alu_result_uart_tx_if bus1 ();

  logic tx0, busy0, done0;
  logic tx1, busy1, done1;

  alu_result_uart_tx #(.CLK_DIV(4)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus0),
    .tx      (tx0),
    .busy    (busy0),
    .tx_done (done0)
  );

  alu_result_uart_tx #(.CLK_DIV(2)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus1),
    .tx      (tx1),
    .busy    (busy1),
    .tx_done (done1)
  );

  int checks = 0;
  int failures = 0;
  int cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted byte becomes a frame that starts on the cycle after
  // its accept edge, or when the previous frame ends, whichever is later.
  int         fs [2][64];
  int         fe [2][64];
  logic [7:0] fb [2][64];
  int         nf [2];
  int         pend [2];
  int         ndone [2];

  function automatic int divof(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic void model(input int d, input int c,
                                output logic etx, output logic edn,
                                output logic ebs, output logic erd);
    int s, e, b, dv;
    dv  = divof(d);
    etx = 1'b1;
    edn = 1'b0;
    ebs = 1'b0;
    erd = 1'b1;
    for (int k = 0; k < nf[d]; k++) begin
      s = fs[d][k];
      e = fe[d][k];
      if (c >= e && c < s) begin
        ebs = 1'b1;
        erd = 1'b0;
      end
      if (c >= s && c < s + 10 * dv) begin
        ebs = 1'b1;
        b = (c - s) / dv;
        if (b == 0)     etx = 1'b0;
        else if (b < 9) etx = fb[d][k][b-1];
        edn = (c == s + 10 * dv - 1);
      end
    end
  endfunction

  // Mid-bit sampling receiver, independent of the model
  int         ridx [2];
  int         rcnt [2];
  logic [7:0] rsh [2];
  logic [7:0] rxb [2][16];
  int         nrx [2] = '{0, 0};

  logic m_tx, m_dn, m_bs, m_rd;
  logic a_tx, a_dn, a_bs, a_rd, a_v;
  logic [7:0] a_dat;
  int acc_e, acc_s, dv;

  initial begin
    ndone[0] = 0;
    ndone[1] = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        nf[d]   = 0;
        pend[d] = 0;
        ridx[d] = -1;
        rcnt[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        dv    = divof(d);
        a_tx  = (d == 0) ? tx0 : tx1;
        a_dn  = (d == 0) ? done0 : done1;
        a_bs  = (d == 0) ? busy0 : busy1;
        a_rd  = (d == 0) ? bus0.res_ready : bus1.res_ready;
        a_v   = (d == 0) ? bus0.res_valid : bus1.res_valid;
        a_dat = (d == 0) ? bus0.res_data : bus1.res_data;
        model(d, cyc, m_tx, m_dn, m_bs, m_rd);
        chk($sformatf("m_tx%0d", d), 32'(a_tx), 32'(m_tx));
        chk($sformatf("m_done%0d", d), 32'(a_dn), 32'(m_dn));
        chk($sformatf("m_busy%0d", d), 32'(a_bs), 32'(m_bs));
        chk($sformatf("m_ready%0d", d), 32'(a_rd), 32'(m_rd));
        if (a_v && m_rd && nf[d] < 64) begin
          acc_e = cyc + 1;
          acc_s = (acc_e + 1 > pend[d]) ? acc_e + 1 : pend[d];
          fe[d][nf[d]] = acc_e;
          fs[d][nf[d]] = acc_s;
          fb[d][nf[d]] = a_dat;
          nf[d]++;
          pend[d] = acc_s + 10 * dv;
        end
        if (a_dn === 1'b1) ndone[d]++;
        if (ridx[d] < 0) begin
          if (a_tx === 1'b0) begin
            ridx[d] = 0;
            rcnt[d] = dv + dv / 2;
          end
        end else begin
          rcnt[d]--;
          if (rcnt[d] == 0) begin
            if (ridx[d] < 8) begin
              rsh[d][ridx[d]] = a_tx;
              ridx[d]++;
              rcnt[d] = dv;
            end else begin
              chk($sformatf("rx_stop%0d", d), 32'(a_tx), 32'd1);
              if (nrx[d] < 16) rxb[d][nrx[d]] = rsh[d];
              nrx[d]++;
              ridx[d] = -1;
            end
          end
        end
      end
    end
  end

  int acc;

  task automatic send(input int d, input logic [7:0] b);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    if (d == 0) begin
      bus0.res_data  = b;
      bus0.res_valid = 1'b1;
    end else begin
      bus1.res_data  = b;
      bus1.res_valid = 1'b1;
    end
    do begin
      @(negedge clk);
      ok = (d == 0) ? bus0.res_ready : bus1.res_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: dut %0d byte %0h never accepted", d, b);
    end
    acc = cyc;
    if (d == 0) bus0.res_valid = 1'b0;
    else        bus1.res_valid = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] exp0 [6];
  logic [7:0] exp1 [2];
  int e0, a1, a2;

  initial begin
    exp0 = '{8'hA5, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03};
    exp1 = '{8'h00, 8'hFF};
    bus0.res_valid = 1'b0;
    bus0.res_data  = 8'h00;
    bus1.res_valid = 1'b0;
    bus1.res_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx0), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(bus0.res_ready), 32'd1);
    chk("rst_done", 32'(done0), 32'd0);
    rst_n = 1'b1;
    wait_until(3);

    send(0, 8'hFF);
    e0 = acc;
    wait_until(e0 + 12);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx0), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_done", 32'(done0), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_until(4);
    chk("post_rst_ready", 32'(bus0.res_ready), 32'd1);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    chk("post_rst_tx", 32'(tx0), 32'd1);

    send(0, 8'hA5);
    e0 = acc;
    chk("a5_busy_e0", 32'(busy0), 32'd1);
    chk("a5_tx_e0", 32'(tx0), 32'd1);
    wait_until(e0 + 1);
    chk("a5_start_a", 32'(tx0), 32'd0);
    wait_until(e0 + 4);
    chk("a5_start_b", 32'(tx0), 32'd0);
    wait_until(e0 + 5);
    chk("a5_bit0", 32'(tx0), 32'd1);
    wait_until(e0 + 9);
    chk("a5_bit1", 32'(tx0), 32'd0);
    wait_until(e0 + 36);
    chk("a5_bit7", 32'(tx0), 32'd1);
    wait_until(e0 + 39);
    chk("a5_done_early", 32'(done0), 32'd0);
    wait_until(e0 + 40);
    chk("a5_done", 32'(done0), 32'd1);
    wait_until(e0 + 41);
    chk("a5_busy_fall", 32'(busy0), 32'd0);
    chk("a5_done_once", 32'(done0), 32'd0);
    wait_until(e0 + 45);

    send(0, 8'h12);
    e0 = acc;
    send(0, 8'h34);
    chk("b2b_accept_gap", 32'(acc - e0), 32'd2);
    wait_until(e0 + 40);
    chk("b2b_done1", 32'(done0), 32'd1);
    chk("b2b_stop1", 32'(tx0), 32'd1);
    wait_until(e0 + 41);
    chk("b2b_start2", 32'(tx0), 32'd0);
    chk("b2b_busy", 32'(busy0), 32'd1);
    wait_until(e0 + 80);
    chk("b2b_done2", 32'(done0), 32'd1);
    wait_until(e0 + 81);
    chk("b2b_busy_fall", 32'(busy0), 32'd0);
    wait_until(e0 + 85);

    send(0, 8'h01);
    a1 = acc;
    send(0, 8'h02);
    a2 = acc;
    chk("bp_ready_low", 32'(bus0.res_ready), 32'd0);
    chk("bp_gap2", 32'(a2 - a1), 32'd2);
    send(0, 8'h03);
    chk("bp_gap3", 32'(acc - a1), 32'd42);
    wait_until(a1 + 130);
    chk("bp_idle", 32'(busy0), 32'd0);

    send(1, 8'h00);
    e0 = acc;
    send(1, 8'hFF);
    wait_until(e0 + 18);
    chk("d2_bit7_zero", 32'(tx1), 32'd0);
    wait_until(e0 + 19);
    chk("d2_stop_a", 32'(tx1), 32'd1);
    wait_until(e0 + 20);
    chk("d2_stop_b", 32'(tx1), 32'd1);
    chk("d2_done1", 32'(done1), 32'd1);
    wait_until(e0 + 21);
    chk("d2_start2", 32'(tx1), 32'd0);
    wait_until(e0 + 23);
    chk("d2_bit0_one", 32'(tx1), 32'd1);
    wait_until(e0 + 40);
    chk("d2_done2", 32'(done1), 32'd1);
    wait_until(e0 + 41);
    chk("d2_busy_fall", 32'(busy1), 32'd0);
    wait_until(e0 + 50);

    chk("rx_count0", 32'(nrx[0]), 32'd6);
    chk("rx_count1", 32'(nrx[1]), 32'd2);
    chk("done_count0", 32'(ndone[0]), 32'd6);
    chk("done_count1", 32'(ndone[1]), 32'd2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rx0_byte%0d", i), 32'(rxb[0][i]), 32'(exp0[i]));
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rx1_byte%0d", i), 32'(rxb[1][i]), 32'(exp1[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
